reg_load: RTL
=============

# reg_load

Serial-to-register loader: receives raw 8N1 UART bytes on `PhyIn` and assembles every four consecutive bytes, least-significant byte first, into a 32-bit word. On completion it presents the word on `Reg` with a one-cycle `RegValid` strobe. It is the receive-side counterpart of the register print path and sits between the board's serial input pin and any debug register or core load port. It contains its own oversampling receiver and has no dependency on a separate RX module.

## Interface
- `PRESCALER`, 625: `BusClk` cycles per bit time; must be ≥ 4.
- `TIMEOUT`, 20: idle bit times after which a partially assembled word is discarded; must be ≥ 1.

- `BusClk`  in  1  bus clock; all logic on its rising edge.
- `BusRstN`  in  1  asynchronous, active-low reset.
- `PhyIn`  in  1  serial line, idle high, asynchronous to `BusClk`.
- `Reg`  out  32  last completed word.
- `RegValid`  out  1  one-cycle pulse: `Reg` has just been updated.
- `FrameErr`  out  1  one-cycle pulse: bad stop bit, or bad parity when enabled.

## Operation
- **Input synchronizer.** `PhyIn` passes through a 2-FF synchronizer; both FFs reset to 1. All FSM decisions use the synchronized value `RxS`.
- **RX FSM states:** IDLE, START, DATA, (PARITY), STOP, WAIT_HIGH.
  - IDLE: when `RxS`=0, clear the bit counter and go to START.
  - START: wait `PRESCALER/2` cycles, then sample. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE without any output.
  - DATA: sample every `PRESCALER` cycles. Shift bits in LSB first. After the 8th sample, go to STOP (or PARITY when enabled).
  - STOP: wait `PRESCALER` cycles, then sample.
    - Sample = 1: byte accepted; go to IDLE.
    - Sample = 0: pulse `FrameErr`, discard the byte, clear the byte count and partial word, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `RxS`=1, then go to IDLE.
- **Word assembly.**
  - Accepted byte: `Asm <= {byte, Asm[31:8]}`, `ByteCnt <= ByteCnt + 1` (2-bit).
  - On the 4th accepted byte (`ByteCnt`=3): `Reg <= {byte, Asm[31:8]}`, pulse `RegValid`, wrap `ByteCnt` to 0.
  - `Reg` holds its value until the next completed word.
- **Timeout.**
  - While in IDLE with `ByteCnt`≠0, an idle counter counts cycles. It clears on any exit from IDLE.
  - When it reaches `TIMEOUT*PRESCALER`, clear `ByteCnt` and `Asm`. No output pulse.
  - Counter width: `$clog2(TIMEOUT*PRESCALER+1)`. Bit-timer width: `$clog2(PRESCALER)`.
- **Simultaneous events.**
  - A timeout and a start edge in the same cycle: the timeout wins and the new byte starts word 0.
  - A `FrameErr` never coincides with `RegValid`.

## Timing
- **Reset values:** `Reg`=0, `RegValid`=0, `FrameErr`=0, FSM=IDLE, `ByteCnt`=0, synchronizer FFs=1.
- **Reset mid-frame:** all state clears immediately. Receiving resumes on the first falling edge after reset is released.
- **Input latency:** 2 cycles from the `PhyIn` edge to `RxS`.
- **Sampling points:**
  - Start bit sampled at `PRESCALER/2` cycles after it is detected on `RxS`.
  - Each later bit sampled at `PRESCALER` cycle intervals after that.
- **Output latency:**
  - `RegValid` and `Reg` update on the clock edge right after the STOP sample of the 4th byte.
  - `FrameErr` is asserted on the clock edge right after the failing sample.
- **Back-to-back frames:** a new start bit may begin immediately after the stop-bit sample; no inter-byte gap is required.
- **Handshake:** none. A consumer must capture `Reg` during the `RegValid` cycle or any time before the next pulse.

## Configuration
- `REG_LOAD_PARITY_EN`
  - Defined: an even-parity bit follows the 8 data bits and is sampled in the PARITY state. On mismatch the FSM still waits out the stop bit. It then pulses `FrameErr`, discards the byte, resets the word, and goes to WAIT_HIGH if the stop bit is 0, otherwise to IDLE.
  - Undefined: plain 8N1. The PARITY state and its logic are not synthesized.

## Test plan
- `PRESCALER`=16, send bytes EF BE AD DE back-to-back → `Reg`=0xDEADBEEF, exactly one `RegValid` pulse, `FrameErr` never asserted.
- Pull `PhyIn` low for 4 cycles, then hold it high → no `RegValid`, no `FrameErr`, FSM back in IDLE.
- Send 11, then 22 with stop bit = 0, then 78 56 34 12 → one `FrameErr` pulse after 22, then `Reg`=0x12345678.
- `TIMEOUT`=2: send AA BB, idle for 3 bit times, then send 01 02 03 04 → `Reg`=0x04030201, with no earlier `RegValid`.
- Assert `BusRstN` low in the middle of the 2nd byte, release it, send 0xCAFEF00D as 0D F0 FE CA → `Reg`=0xCAFEF00D.
- With `REG_LOAD_PARITY_EN` defined: send 0x01 with parity bit 0 → `FrameErr` pulse; then send 4 correct bytes 01 00 00 00 → `Reg`=0x00000001.

Source files
------------

// File: rtl/reg_load.sv
// reg_load: oversampling 8N1 UART receiver that packs four LSB-first bytes into a 32-bit word.
// Optional: define REG_LOAD_PARITY_EN to expect an even-parity bit between data and stop.
module reg_load #(
    parameter int PRESCALER = 625,
    parameter int TIMEOUT   = 20
) (
    input  logic        BusClk,
    input  logic        BusRstN,
    input  logic        PhyIn,
    output logic [31:0] Reg,
    output logic        RegValid,
    output logic        FrameErr
);
    localparam int TMR_W     = $clog2(PRESCALER);
    localparam int TO_CYCLES = TIMEOUT * PRESCALER;
    localparam int IDLE_W    = $clog2(TO_CYCLES + 1);

    localparam logic [TMR_W-1:0]  HALF_M1  = TMR_W'(PRESCALER / 2 - 1);
    localparam logic [TMR_W-1:0]  FULL_M1  = TMR_W'(PRESCALER - 1);
    localparam logic [IDLE_W-1:0] TO_LIMIT = IDLE_W'(TO_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef REG_LOAD_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t              state_q;
    logic                sync1_q;
    logic                rxs_q;
    logic [TMR_W-1:0]    tmr_q;
    logic [2:0]          bit_cnt_q;
    logic [7:0]          shift_q;
    logic [1:0]          byte_cnt_q;
    logic [31:0]         asm_q;
    logic [IDLE_W-1:0]   idle_q;
    logic [31:0]         word_q;
    logic                reg_valid_q;
    logic                frame_err_q;
    logic                byte_bad;
    logic                tick;

    assign tick = (tmr_q == FULL_M1);

    always_ff @(posedge BusClk or negedge BusRstN) begin
        if (!BusRstN) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= PhyIn;
            rxs_q   <= sync1_q;
        end
    end

`ifdef REG_LOAD_PARITY_EN
    logic par_err_q;

    // Even parity: the data bits plus the parity bit must hold an even number of ones.
    always_ff @(posedge BusClk or negedge BusRstN) begin
        if (!BusRstN) begin
            par_err_q <= 1'b0;
        end else if (state_q == S_PARITY && tick) begin
            par_err_q <= rxs_q ^ (^shift_q);
        end
    end
    assign byte_bad = par_err_q;
`else
    assign byte_bad = 1'b0;
`endif

    always_ff @(posedge BusClk or negedge BusRstN) begin
        if (!BusRstN) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            idle_q      <= '0;
            word_q      <= '0;
            reg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            reg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Timeout is evaluated first so a coinciding start bit begins a fresh word.
                    if (byte_cnt_q != 2'd0) begin
                        if (idle_q == TO_LIMIT) begin
                            byte_cnt_q <= '0;
                            asm_q      <= '0;
                            idle_q     <= '0;
                        end else begin
                            idle_q <= idle_q + 1'b1;
                        end
                    end
                    if (!rxs_q) begin
                        state_q   <= S_START;
                        tmr_q     <= '0;
                        bit_cnt_q <= '0;
                        idle_q    <= '0;
                    end
                end
                S_START: begin
                    if (tmr_q == HALF_M1) begin
                        tmr_q   <= '0;
                        state_q <= rxs_q ? S_IDLE : S_DATA;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        tmr_q     <= '0;
                        shift_q   <= {rxs_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef REG_LOAD_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
`ifdef REG_LOAD_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        tmr_q   <= '0;
                        state_q <= S_STOP;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        tmr_q   <= '0;
                        state_q <= rxs_q ? S_IDLE : S_WAIT_HIGH;
                        if (rxs_q && !byte_bad) begin
                            asm_q      <= {shift_q, asm_q[31:8]};
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            if (byte_cnt_q == 2'd3) begin
                                word_q      <= {shift_q, asm_q[31:8]};
                                reg_valid_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            byte_cnt_q  <= '0;
                            asm_q       <= '0;
                        end
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Reg      = word_q;
    assign RegValid = reg_valid_q;
    assign FrameErr = frame_err_q;
endmodule
